// File: rtl/mips_regfile_wr_arbiter.sv
// Register-file write arbiter for a MIPS-style pipeline.
// After reset it clears r1..r31 (one write per cycle), then arbitrates
// load, ALU and jump-and-link writeback requests onto a single registered
// write port, either round-robin (LD, ALU, JAL) or fixed priority.
module mips_regfile_wr_arbiter #(
  parameter int unsigned RR_EN = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        alu_valid,
  input  logic [4:0]  alu_reg,
  input  logic [31:0] alu_data,
  output logic        alu_ready,
  input  logic        ld_valid,
  input  logic [4:0]  ld_reg,
  input  logic [31:0] ld_data,
  output logic        ld_ready,
  input  logic        jal_valid,
  input  logic [12:0] jal_address,
  output logic        jal_ready,
  output logic        signal_reg_write,
  output logic [4:0]  write_reg,
  output logic [31:0] write_data,
  output logic        init_done
);

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  typedef enum logic [1:0] {
    PTR_LD  = 2'd0,
    PTR_ALU = 2'd1,
    PTR_JAL = 2'd2
  } ptr_t;

  state_t      state;
  state_t      state_next;
  logic [4:0]  init_idx;
  ptr_t        last_grant;

  logic        grant_ld;
  logic        grant_alu;
  logic        grant_jal;
  logic        any_grant;
  logic [4:0]  sel_reg;
  logic [31:0] sel_data;
  logic [12:0] link_addr;

  // Return address written to r31 is the jump address minus one, wrapping in 13 bits.
  assign link_addr = jal_address - 13'd1;

  // Pick at most one requester; nothing is granted while clearing the register file.
  always_comb begin
    grant_ld  = 1'b0;
    grant_alu = 1'b0;
    grant_jal = 1'b0;
    if (state == ST_RUN) begin
      if (RR_EN != 0) begin
        // Search starts at the requester after the last one granted.
        case (last_grant)
          PTR_LD: begin
            if (alu_valid)      grant_alu = 1'b1;
            else if (jal_valid) grant_jal = 1'b1;
            else if (ld_valid)  grant_ld  = 1'b1;
          end
          PTR_ALU: begin
            if (jal_valid)      grant_jal = 1'b1;
            else if (ld_valid)  grant_ld  = 1'b1;
            else if (alu_valid) grant_alu = 1'b1;
          end
          default: begin
            if (ld_valid)       grant_ld  = 1'b1;
            else if (alu_valid) grant_alu = 1'b1;
            else if (jal_valid) grant_jal = 1'b1;
          end
        endcase
      end else begin
        if (ld_valid)       grant_ld  = 1'b1;
        else if (alu_valid) grant_alu = 1'b1;
        else if (jal_valid) grant_jal = 1'b1;
      end
    end
  end

  assign ld_ready  = grant_ld;
  assign alu_ready = grant_alu;
  assign jal_ready = grant_jal;
  assign any_grant = grant_ld | grant_alu | grant_jal;

  // Route the granted requester's destination and data to the write port.
  always_comb begin
    sel_reg  = '0;
    sel_data = '0;
    if (grant_ld) begin
      sel_reg  = ld_reg;
      sel_data = ld_data;
    end else if (grant_alu) begin
      sel_reg  = alu_reg;
      sel_data = alu_data;
    end else if (grant_jal) begin
      sel_reg  = 5'd31;
      sel_data = {19'b0, link_addr};
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_INIT;
    else        state <= state_next;
  end

  // Leave INIT once the r31 clear has been issued.
  always_comb begin
    state_next = state;
    if (state == ST_INIT && init_idx == 5'd31) state_next = ST_RUN;
  end

  // Clear-sequence index, walking r1..r31.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      init_idx <= 5'd1;
    end else if (state == ST_INIT && init_idx != 5'd31) begin
      init_idx <= init_idx + 5'd1;
    end
  end

  // Round-robin pointer remembers the last requester granted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant <= PTR_JAL;
    end else if (grant_ld) begin
      last_grant <= PTR_LD;
    end else if (grant_alu) begin
      last_grant <= PTR_ALU;
    end else if (grant_jal) begin
      last_grant <= PTR_JAL;
    end
  end

  // Registered write port; r0 grants complete the handshake but never write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      signal_reg_write <= 1'b0;
      write_reg        <= '0;
      write_data       <= '0;
      init_done        <= 1'b0;
    end else if (state == ST_INIT) begin
      signal_reg_write <= 1'b1;
      write_reg        <= init_idx;
      write_data       <= '0;
      if (init_idx == 5'd31) init_done <= 1'b1;
    end else begin
      signal_reg_write <= any_grant && (sel_reg != 5'd0);
      if (any_grant) begin
        write_reg  <= sel_reg;
        write_data <= sel_data;
      end
    end
  end

endmodule
